// File: rtl/multi_delay_timer.sv
// Multi-channel programmable delay timer.
// Each channel runs a periodic or one-shot counter that emits tick/status flags.
module multi_delay_timer #(
    parameter int CHANNELS  = 4,
    parameter int CBITS     = 11,
    parameter int N_DEFAULT = 1250,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CW-1:0]       cfg_ch,
    input  logic [CBITS-1:0]    cfg_period,
    input  logic                cfg_oneshot,
    input  logic [CHANNELS-1:0] start,
    input  logic [CHANNELS-1:0] enable,
    output logic [CHANNELS-1:0] sig,
    output logic [CHANNELS-1:0] flg,
    output logic [CHANNELS-1:0] err,
    output logic [CHANNELS-1:0] busy
);

    // Parameter sanity: refuse to elaborate an unrepresentable default period.
    if (N_DEFAULT < 0 || N_DEFAULT >= (2 ** CBITS)) begin : g_bad_default
        $error("N_DEFAULT must fit in CBITS bits");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("CHANNELS must be in 1..16");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CBITS-1:0] PDEF = CBITS'(N_DEFAULT);

    state_t           state_q   [CHANNELS];
    state_t           state_d   [CHANNELS];
    logic [CBITS-1:0] cnt_q     [CHANNELS];
    logic [CBITS-1:0] cnt_d     [CHANNELS];
    logic [CBITS-1:0] period_q  [CHANNELS];
    logic [CBITS-1:0] period_d  [CHANNELS];
    logic             oneshot_q [CHANNELS];
    logic             oneshot_d [CHANNELS];

    // Per-channel state register with synchronous reset to free-running default.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= RUN;
                cnt_q[i]     <= '0;
                period_q[i]  <= PDEF;
                oneshot_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= state_d[i];
                cnt_q[i]     <= cnt_d[i];
                period_q[i]  <= period_d[i];
                oneshot_q[i] <= oneshot_d[i];
            end
        end
    end

    // Next state: cfg write beats start, start beats counting/wrapping.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];
            period_d[i]  = period_q[i];
            oneshot_d[i] = oneshot_q[i];
            if (cfg_we && (cfg_ch == CW'(i))) begin
                period_d[i]  = cfg_period;
                oneshot_d[i] = cfg_oneshot;
                cnt_d[i]     = '0;
                state_d[i]   = RUN;
            end else if (start[i]) begin
                cnt_d[i]   = '0;
                state_d[i] = RUN;
            end else if (state_q[i] == RUN && enable[i]) begin
                if (cnt_q[i] < period_q[i]) begin
                    cnt_d[i] = cnt_q[i] + CBITS'(1);
                end else begin
                    cnt_d[i] = '0;
                    if (oneshot_q[i]) begin
                        state_d[i] = IDLE;
                    end
                end
            end
        end
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        sig  = '0;
        flg  = '0;
        err  = '0;
        busy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            busy[i] = (state_q[i] == RUN);
            sig[i]  = (state_q[i] == RUN) && (cnt_q[i] >= period_q[i]);
            flg[i]  = (state_q[i] == RUN) && (cnt_q[i] < period_q[i]);
            err[i]  = (cnt_q[i] > period_q[i]);
        end
    end

endmodule
